// File: rtl/video_capture.sv
// Receive side of the parallel RGB565 video interface: locks to frame boundaries, packs valid
// pixels into DATA_W*PACK-bit write words and measures line length / line count per frame.
module video_capture #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PACK   = 8,
    parameter int unsigned H_DISP = 1280,
    parameter int unsigned V_DISP = 720
) (
    input  logic                   pixel_clk,
    input  logic                   sys_rst_n,
    input  logic                   cap_en,
    input  logic                   img_hsync,
    input  logic                   img_vsync,
    input  logic                   img_valid,
    input  logic [DATA_W-1:0]      img_data,
    input  logic                   wr_full,
    output logic                   wr_en,
    output logic [DATA_W*PACK-1:0] wr_data,
    output logic                   frame_start,
    output logic                   frame_done,
    output logic                   cap_busy,
    output logic [10:0]            line_len,
    output logic [9:0]             line_cnt,
    output logic                   err_line,
    output logic                   err_frame,
    output logic                   err_ovf
);

    localparam int unsigned IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK - 1);

    typedef enum logic [1:0] {StIdle, StArm, StCapture, StDone} state_e;

    state_e state_q;

    logic              vsync_q, vsync_prev_q;
    logic              valid_q, valid_prev_q;
    logic [DATA_W-1:0] data_q;

    logic [PACK-1:0][DATA_W-1:0] pack_q;
    logic [PACK-1:0][DATA_W-1:0] full_word;
    logic [PACK-1:0][DATA_W-1:0] wr_data_q;
    logic [IDX_W-1:0]            pix_idx_q;
    logic [10:0]                 pix_cnt_q;
    logic                        word_pend_q;
    logic                        frame_start_q;
    logic                        frame_done_q;
    logic [10:0]                 line_len_q;
    logic [9:0]                  line_cnt_q;
    logic                        err_line_q;
    logic                        err_frame_q;
    logic                        err_ovf_q;

    logic vsync_rise;
    logic valid_fall;
    logic frame_begin;

    // Line boundaries come from valid only; hsync is deliberately ignored.
    logic unused_hsync;
    assign unused_hsync = img_hsync;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            valid_q      <= 1'b0;
            valid_prev_q <= 1'b0;
            data_q       <= '0;
        end else begin
            vsync_q      <= img_vsync;
            vsync_prev_q <= vsync_q;
            valid_q      <= img_valid;
            valid_prev_q <= valid_q;
            data_q       <= img_data;
        end
    end

    assign vsync_rise  = vsync_q & ~vsync_prev_q;
    assign valid_fall  = ~valid_q & valid_prev_q;
    assign frame_begin = vsync_rise &&
                         (((state_q == StArm) && cap_en) || (state_q == StCapture));

    // The 8th pixel goes straight from the input register into the issued word.
    always_comb begin
        full_word           = pack_q;
        full_word[PACK-1]   = data_q;
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            pack_q        <= '0;
            wr_data_q     <= '0;
            pix_idx_q     <= '0;
            pix_cnt_q     <= '0;
            word_pend_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_len_q    <= '0;
            line_cnt_q    <= '0;
            err_line_q    <= 1'b0;
            err_frame_q   <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            word_pend_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            if (word_pend_q && wr_full) begin
                err_ovf_q <= 1'b1;
            end

            if (frame_begin) begin
                // A vsync rise while already capturing means the previous frame was truncated.
                frame_start_q <= 1'b1;
                line_cnt_q    <= '0;
                pack_q        <= '0;
                pix_idx_q     <= '0;
                pix_cnt_q     <= '0;
                err_line_q    <= 1'b0;
                err_ovf_q     <= 1'b0;
                err_frame_q   <= (state_q == StCapture);
                state_q       <= StCapture;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cap_en) begin
                            state_q <= StArm;
                        end
                    end
                    StArm: begin
                    end
                    StCapture: begin
                        if (valid_q) begin
                            if (pix_cnt_q != 11'h7ff) begin
                                pix_cnt_q <= pix_cnt_q + 11'd1;
                            end
                            if (pix_idx_q == IDX_LAST) begin
                                wr_data_q   <= full_word;
                                word_pend_q <= 1'b1;
                                pack_q      <= '0;
                                pix_idx_q   <= '0;
                            end else begin
                                pack_q[pix_idx_q] <= data_q;
                                pix_idx_q         <= pix_idx_q + IDX_W'(1);
                            end
                        end
                        if (valid_fall) begin
                            line_len_q <= pix_cnt_q;
                            if (pix_cnt_q != 11'(H_DISP)) begin
                                err_line_q <= 1'b1;
                            end
                            // Unused upper slots are already zero in the buffer.
                            if (pix_idx_q != '0) begin
                                wr_data_q   <= pack_q;
                                word_pend_q <= 1'b1;
                            end
                            pack_q     <= '0;
                            pix_idx_q  <= '0;
                            pix_cnt_q  <= '0;
                            line_cnt_q <= line_cnt_q + 10'd1;
                            if (line_cnt_q == 10'(V_DISP - 1)) begin
                                state_q <= StDone;
                            end
                        end
                    end
                    StDone: begin
                        frame_done_q <= 1'b1;
                        state_q      <= cap_en ? StArm : StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // The FIFO accepts a write only when not full, so full is checked in the strobe cycle itself.
    assign wr_en       = word_pend_q & ~wr_full;
    assign wr_data     = wr_data_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign cap_busy    = (state_q == StCapture);
    assign line_len    = line_len_q;
    assign line_cnt    = line_cnt_q;
    assign err_line    = err_line_q;
    assign err_frame   = err_frame_q;
    assign err_ovf     = err_ovf_q;

endmodule
